// File: rtl/cam_pkg.sv
// Shared camera-capture definitions: FSM encoding, default frame geometry
// and the RGB565 -> RGB332 packing used when a pixel completes.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int H_PIX_DEF = 160;
  localparam int V_PIX_DEF = 120;

  // Keep the top 3 red, top 3 green and top 2 blue bits of the 565 pixel.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    logic unused_bits;
    unused_bits = ^{hi[4:3], lo[7:5], lo[2:0]};
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Frame-buffer write port: one address/data word per mem_we cycle.
// No backpressure; the buffer must accept every strobed write.
interface cam_capture_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  modport master (output mem_addr, mem_data, mem_we);
  modport slave  (input  mem_addr, mem_data, mem_we);
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a history flop for edge detection; level is
// 2 clk behind the async input, rise/fall pulse for one clk.
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= sig;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;
endmodule

// File: rtl/cam_capture_ctrl.sv
// Captures one RGB565 camera frame per start into an RGB332 frame buffer;
// a write appears 1 clk after the completing pclk-rise detect, no backpressure.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cam_pclk,
  input  logic                      cam_href,
  input  logic                      cam_vsync,
  input  logic [7:0]                cam_data,
  cam_capture_ctrl_if.master        mem,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overflow
);
  localparam int            NPIX      = H_PIX * V_PIX;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  cap_state_e state;
  logic       phase;
  logic       full;
  logic [7:0] hi_byte;

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vsync_lvl, vsync_rise, vsync_fall;
  logic [7:0] data_lvl, data_rise, data_fall;

  sync_edge #(.WIDTH(1)) u_sync_pclk (
    .clk(clk), .rst_n(rst_n), .sig(cam_pclk),
    .level(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall)
  );
  sync_edge #(.WIDTH(1)) u_sync_href (
    .clk(clk), .rst_n(rst_n), .sig(cam_href),
    .level(href_lvl), .rise(href_rise), .fall(href_fall)
  );
  sync_edge #(.WIDTH(1)) u_sync_vsync (
    .clk(clk), .rst_n(rst_n), .sig(cam_vsync),
    .level(vsync_lvl), .rise(vsync_rise), .fall(vsync_fall)
  );
  sync_edge #(.WIDTH(8)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .sig(cam_data),
    .level(data_lvl), .rise(data_rise), .fall(data_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{pclk_lvl, pclk_fall, href_rise, vsync_lvl, data_rise, data_fall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
      mem.mem_we   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      phase        <= 1'b0;
      full         <= 1'b0;
      hi_byte      <= '0;
    end else begin
      mem.mem_we <= 1'b0;
      frame_done <= 1'b0;

      // Address advances after the write cycle and parks on the last slot.
      if (mem.mem_we) begin
        if (mem.mem_addr == LAST_ADDR) full <= 1'b1;
        else                           mem.mem_addr <= mem.mem_addr + AW'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= WAIT_VS;
            busy         <= 1'b1;
            mem.mem_addr <= '0;
            phase        <= 1'b0;
            overflow     <= 1'b0;
            full         <= 1'b0;
          end
        end
        WAIT_VS: begin
          if (vsync_fall) state <= CAPTURE;
        end
        CAPTURE: begin
          if (href_fall) begin
            phase <= 1'b0;
          end else if (pclk_rise && href_lvl) begin
            phase <= ~phase;
            if (!phase)    hi_byte  <= data_lvl;
            else if (full) overflow <= 1'b1;
            else begin
              mem.mem_we   <= 1'b1;
              mem.mem_data <= DW'(rgb565_to_rgb332(hi_byte, data_lvl));
            end
          end
          if (vsync_rise) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 15, meaning frame-buffer address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning frame-buffer data width (RGB332).
REQ-003 The block SHALL have parameter H_PIX, default 160, meaning pixels per line.
REQ-004 The block SHALL have parameter V_PIX, default 120, meaning lines per frame; H_PIX*V_PIX SHALL be at most 2**AW.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a one-cycle request to capture one frame.
REQ-008 The block SHALL have ports cam_pclk, cam_href and cam_vsync, inputs, 1 bit each, asynchronous camera timing.
REQ-009 The block SHALL have port cam_data, input, 8 bits, camera byte in RGB565 (high byte first).
REQ-010 The block SHALL have port mem_addr, output, AW bits, the buffer write address.
REQ-011 The block SHALL have port mem_data, output, DW bits, the buffer write data.
REQ-012 The block SHALL have port mem_we, output, 1 bit, the buffer write strobe (maps to regwrite).
REQ-013 The block SHALL have port busy, output, 1 bit, high from accepted start to frame end.
REQ-014 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at frame end.
REQ-015 The block SHALL have port overflow, output, 1 bit, sticky flag for pixels beyond H_PIX*V_PIX.

Function
REQ-016 cam_pclk, cam_href, cam_vsync and cam_data SHALL pass through 2-flop synchronizers; a pclk rise is synced-now=1 AND synced-prev=0.
REQ-017 FSM states SHALL be IDLE, WAIT_VS, CAPTURE and DONE.
REQ-018 IDLE SHALL go to WAIT_VS on start=1, clearing mem_addr, the byte phase and overflow.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 WAIT_VS SHALL go to CAPTURE on a synced cam_vsync falling edge.
REQ-021 In CAPTURE, each pclk rise with href=1 SHALL toggle the byte phase: phase 0 latches the high byte, phase 1 completes the pixel.
REQ-022 On pixel completion, mem_data SHALL be {hi[7:5], hi[2:0], lo[4:3]}, with mem_we=1 for exactly one clk cycle, at latency 1 clk after the phase-1 pclk-rise detect cycle.
REQ-023 mem_addr SHALL hold the written address during the mem_we cycle and increment by 1 in the following cycle.
REQ-024 A synced href falling edge SHALL reset the byte phase to 0; an orphan high byte SHALL be discarded.
REQ-025 When H_PIX*V_PIX pixels have been written, further completed pixels SHALL NOT assert mem_we, SHALL NOT advance mem_addr, and SHALL set overflow.
REQ-026 A synced cam_vsync rising edge in CAPTURE SHALL go to DONE; a pixel write already pending SHALL still complete first.
REQ-027 DONE SHALL pulse frame_done for one cycle and return to IDLE on the next cycle.
REQ-028 busy SHALL be 1 in WAIT_VS, CAPTURE and DONE, and 0 in IDLE.
REQ-029 mem_addr SHALL never exceed H_PIX*V_PIX-1, so no wrap-around is possible.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, mem_addr=0, mem_data=0, mem_we=0, busy=0, frame_done=0, overflow=0, byte phase=0, and all synchronizer flops to 0.
REQ-031 A reset mid-frame SHALL abandon the capture, emit no frame_done, and require a new start.

Structure
REQ-032 The FSM state encoding, the RGB565-to-RGB332 packing function and the default H_PIX/V_PIX constants SHALL reside in shared package cam_pkg.
REQ-033 The synchronizer and edge detector SHALL be one sub-module, sync_edge (parameter width, outputs level/rise/fall), instantiated per camera signal.

Verification
REQ-034 Bench SHALL check: reset, then start with a 4x2 frame (H_PIX=4, V_PIX=2) using bytes hi=0xF8, lo=0x00 -> 8 writes of 0xE0 at addr 0..7, one frame_done, busy 0 afterwards.
REQ-035 Bench SHALL check: pixel hi=0x07, lo=0xE0 -> mem_data=0x1C; hi=0x00, lo=0x1F -> mem_data=0x03.
REQ-036 Bench SHALL check: 9 pixels into a 4x2 frame -> 8 writes, mem_addr holds 7, overflow=1 until the next start.
REQ-037 Bench SHALL check: a line ending on an odd byte count -> the orphan byte is dropped and the next line's first pixel writes the correct value.
REQ-038 Bench SHALL check: rst_n low mid-CAPTURE -> all outputs 0 immediately, no frame_done; a start while busy -> ignored.
REQ-039 Bench SHALL check: start asserted, then vsync held high for 1000 cycles -> busy=1 in WAIT_VS, zero writes.
